serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Transmitter counterpart to the team's Moore "00110" sequence detector.
- On a start request, drives a serial line with the 5-bit sync preamble 00110, then a DATA_W-bit payload MSB-first, then an optional even-parity bit.
- Between frames the line idles at 1, so it never presents spurious zeros to the detector.
- Sits on the same serial link as the detector's `w` input and feeds it directly in loopback benches.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PREAMBLE, 5'b00110, sync pattern, sent MSB first.
- PRE_LEN, 5, preamble length in bits.
- PARITY_EN, 1, 1 = append even-parity bit after payload; 0 = no parity bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled on rising clk.
- data  in  DATA_W  payload; captured only when start is accepted.
- w  out  1  serial line, registered output.
- busy  out  1  high while a frame is on the line.
- done  out  1  one-cycle pulse after the last frame bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; w=1, busy=0, done=0; counters and shift register cleared.
  - Takes effect immediately, including mid-frame.
  - The aborted frame produces no done pulse.
- Accept rule:
  - start is accepted on a rising edge where state=IDLE (busy=0).
  - data is latched into the shift register on that same edge.
  - start while busy=1 is ignored; the latched data is not changed.
  - start is level-sampled: holding it high re-arms a new frame at every IDLE edge.
- States:
  - IDLE: w=1, busy=0.
    - start=1 -> PRE, pre_cnt=0.
  - PRE: w=PREAMBLE[PRE_LEN-1-pre_cnt].
    - Stays PRE_LEN cycles, then -> DATA with bit_cnt=0.
  - DATA: w=shift MSB; shift left each cycle.
    - Stays DATA_W cycles.
    - Then -> PAR if PARITY_EN=1, else -> IDLE with done=1.
  - PAR: w = XOR of the latched payload (even parity: total ones in payload plus parity bit is even).
    - 1 cycle, then -> IDLE with done=1.
- Timing:
  - The first preamble bit appears on w in the cycle after the accepting edge.
  - busy is high for exactly PRE_LEN+DATA_W+PARITY_EN cycles, aligned with the frame bits on w.
  - done is high for 1 cycle, coincident with the first IDLE cycle (w=1, busy=0).
- Back-to-back frames:
  - start may be accepted in the done cycle.
  - Minimum inter-frame gap on w is therefore exactly one idle bit (1).
- Counters are sized as $clog2 of their range, minimum 1 bit. Counters never wrap: state exits at count = length-1.
- Parity is computed from the latched copy of data, not from the live port.
- Illegal state encodings -> IDLE on the next edge, with w=1 and busy=0.
- Outputs w, busy and done are registered; there is no combinational path from start or data to any output.

Test Plan:
- Reset then idle 10 cycles, start=0 -> w=1, busy=0, done=0 throughout.
- DATA_W=8, PARITY_EN=1, start pulse with data=8'hA5:
  - w sequence: 0,0,1,1,0, 1,0,1,0,0,1,0,1, 0.
  - busy high 14 cycles; done pulses in cycle 15; w=1 afterwards.
- data=8'h07, PARITY_EN=1 -> parity bit=1. With PARITY_EN=0 -> busy=13 cycles, no parity bit, done in cycle 14.
- start held high continuously with data=8'hFF:
  - frames repeat with exactly one w=1 gap bit between them.
  - done pulses each gap cycle; changing data mid-frame does not alter the current payload.
- Assert reset low at the 3rd payload bit:
  - w=1 and busy=0 immediately (before the next clk edge); no done pulse.
  - A start after release transmits a full fresh frame.
- Loopback into the "00110" detector, 3 frames with payloads 8'h00, 8'h3C, 8'hFF -> detector z asserts once per frame, after the preamble.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync preamble, MSB-first payload, optional
// even parity. The line idles high between frames.
module serial_frame_tx #(
    parameter int                 DATA_W    = 8,
    parameter int                 PRE_LEN   = 5,
    parameter logic [PRE_LEN-1:0] PREAMBLE  = 5'b00110,
    parameter int                 PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              w,
    output logic              busy,
    output logic              done
);

    localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [PW-1:0]       pre_cnt, pre_cnt_n;
    logic [BW-1:0]       bit_cnt, bit_cnt_n;
    logic [PRE_LEN-1:0]  pre_sh, pre_sh_n;
    logic [DATA_W-1:0]   shift, shift_n;
    logic                par, par_n;
    logic                w_n, busy_n, done_n;

    always_comb begin
        state_n   = state;
        pre_cnt_n = pre_cnt;
        bit_cnt_n = bit_cnt;
        pre_sh_n  = pre_sh;
        shift_n   = shift;
        par_n     = par;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = PRE;
                    pre_cnt_n = '0;
                    pre_sh_n  = PREAMBLE;
                    shift_n   = data;
                    par_n     = ^data;
                end
            end
            PRE: begin
                if (pre_cnt == PW'(PRE_LEN - 1)) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end else begin
                    pre_cnt_n = pre_cnt + 1'b1;
                    pre_sh_n  = pre_sh << 1;
                end
            end
            DATA: begin
                if (bit_cnt == BW'(DATA_W - 1)) begin
                    if (PARITY_EN != 0) begin
                        state_n = PAR;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    shift_n   = shift << 1;
                end
            end
            PAR: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from the next state so they register in step
        w_n    = 1'b1;
        busy_n = 1'b0;
        case (state_n)
            PRE: begin
                w_n    = pre_sh_n[PRE_LEN-1];
                busy_n = 1'b1;
            end
            DATA: begin
                w_n    = shift_n[DATA_W-1];
                busy_n = 1'b1;
            end
            PAR: begin
                w_n    = par_n;
                busy_n = 1'b1;
            end
            default: begin
                w_n    = 1'b1;
                busy_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pre_cnt <= '0;
            bit_cnt <= '0;
            pre_sh  <= '0;
            shift   <= '0;
            par     <= 1'b0;
            w       <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_cnt_n;
            bit_cnt <= bit_cnt_n;
            pre_sh  <= pre_sh_n;
            shift   <= shift_n;
            par     <= par_n;
            w       <= w_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule
